// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard controller.
//   - hz_state_e  : hazard FSM states (RUN, MEM_WAIT, HALT)
//   - pipe_ctrl_t : bundle of pipeline-register enables and bubble requests
//   - CNT_W       : performance counter width
//   - sat_inc     : saturating increment used by the performance counters
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]     perf_cnt_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } hz_state_e;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctrl_t;

    // Normal flow: every stage advances, no bubbles.
    localparam pipe_ctrl_t CTRL_RUN = '{pc_we: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1,
                                        ex_mem_we: 1'b1, mem_wb_we: 1'b1,
                                        if_id_flush: 1'b0, id_ex_flush: 1'b0};
    // Data memory not done: freeze the whole pipeline.
    localparam pipe_ctrl_t CTRL_STALL = '{pc_we: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0,
                                          ex_mem_we: 1'b0, mem_wb_we: 1'b0,
                                          if_id_flush: 1'b0, id_ex_flush: 1'b0};
    // ECALL/EBREAK in EX: stop fetch, squash younger work, let older work drain.
    localparam pipe_ctrl_t CTRL_DRAIN = '{pc_we: 1'b0, if_id_we: 1'b1, id_ex_we: 1'b1,
                                          ex_mem_we: 1'b1, mem_wb_we: 1'b1,
                                          if_id_flush: 1'b1, id_ex_flush: 1'b1};
    // Halted: only the back end keeps moving so in-flight results retire.
    localparam pipe_ctrl_t CTRL_HALT = '{pc_we: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0,
                                         ex_mem_we: 1'b1, mem_wb_we: 1'b1,
                                         if_id_flush: 1'b0, id_ex_flush: 1'b0};
    // Taken branch: redirect PC and squash the two wrong-path instructions.
    localparam pipe_ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1,
                                           ex_mem_we: 1'b1, mem_wb_we: 1'b1,
                                           if_id_flush: 1'b1, id_ex_flush: 1'b1};
    // Load-use: hold PC and IF/ID, push one bubble into ID/EX.
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{pc_we: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b1,
                                             ex_mem_we: 1'b1, mem_wb_we: 1'b1,
                                             if_id_flush: 1'b0, id_ex_flush: 1'b1};
    // Reset cycle: nothing is written, both front registers are bubbled.
    localparam pipe_ctrl_t CTRL_RESET = '{pc_we: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0,
                                          ex_mem_we: 1'b0, mem_wb_we: 1'b0,
                                          if_id_flush: 1'b1, id_ex_flush: 1'b1};

    function automatic perf_cnt_t sat_inc(input perf_cnt_t v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + perf_cnt_t'(1'b1);
        end
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detector.sv
// Load-use hazard detector (purely combinational).
//   rs1, rs2           : source registers of the instruction in ID
//   rs1_used, rs2_used : the ID instruction really reads that source
//   rd                 : destination register of the instruction in EX
//   mem_read           : the EX instruction is a load
//   load_use           : ID needs a value the EX load has not produced yet
module pipeline_hazard_ctrl_load_use_detector
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic                 rs1_used,
    input  logic                 rs2_used,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 mem_read,
    output logic                 load_use
);

    logic rs1_match_s;
    logic rs2_match_s;

    assign rs1_match_s = rs1_used && (rs1 == rd);
    assign rs2_match_s = rs2_used && (rs2 == rd);

    // x0 is hard-wired to zero, so a load targeting it can never feed a consumer.
    assign load_use = mem_read && (rd != {REG_IDX_W{1'b0}}) && (rs1_match_s || rs2_match_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller.
//   Inputs : ID source registers and use flags, EX destination/load flag,
//            taken-branch, data-memory busy and ECALL/EBREAK indications.
//   Outputs: pipeline register write enables, IF/ID and ID/EX bubble
//            requests (combinational, same cycle), halted flag, and
//            saturating stall / flush performance counters (registered).
// Event priority: memory busy > halt > taken branch > load-use.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [REG_IDX_W-1:0] rs1_if_id_i,
    input  logic [REG_IDX_W-1:0] rs2_if_id_i,
    input  logic                 rs1_used_if_id_en,
    input  logic                 rs2_used_if_id_en,
    input  logic [REG_IDX_W-1:0] rd_id_ex_i,
    input  logic                 mem_read_id_ex_en,
    input  logic                 branch_taken_ex_i,
    input  logic                 dmem_busy_i,
    input  logic                 halt_ex_i,
    output logic                 pc_write_en_o,
    output logic                 if_id_write_en_o,
    output logic                 id_ex_write_en_o,
    output logic                 ex_mem_write_en_o,
    output logic                 mem_wb_write_en_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_flush_o,
    output logic                 halted_o,
    output logic [CNT_W-1:0]     stall_count_o,
    output logic [CNT_W-1:0]     flush_count_o
);

    hz_state_e  state_r;
    hz_state_e  next_state_s;
    pipe_ctrl_t ctrl_s;
    perf_cnt_t  stall_cnt_r;
    perf_cnt_t  flush_cnt_r;
    logic       load_use_s;

    pipeline_hazard_ctrl_load_use_detector u_load_use_detector (
        .rs1      (rs1_if_id_i),
        .rs2      (rs2_if_id_i),
        .rs1_used (rs1_used_if_id_en),
        .rs2_used (rs2_used_if_id_en),
        .rd       (rd_id_ex_i),
        .mem_read (mem_read_id_ex_en),
        .load_use (load_use_s)
    );

    // Control decode and next-state selection from current state and live events.
    always_comb begin
        ctrl_s       = CTRL_RUN;
        next_state_s = state_r;
        if (!rst_ni) begin
            ctrl_s       = CTRL_RESET;
            next_state_s = ST_RUN;
        end else begin
            case (state_r)
                // MEM_WAIT decodes exactly like RUN: once the memory is done the
                // pending branch/halt/load-use is acted on in that same cycle.
                ST_RUN, ST_MEM_WAIT: begin
                    if (dmem_busy_i) begin
                        ctrl_s       = CTRL_STALL;
                        next_state_s = ST_MEM_WAIT;
                    end else if (halt_ex_i) begin
                        ctrl_s       = CTRL_DRAIN;
                        next_state_s = ST_HALT;
                    end else if (branch_taken_ex_i) begin
                        ctrl_s       = CTRL_BRANCH;
                        next_state_s = ST_RUN;
                    end else if (load_use_s) begin
                        ctrl_s       = CTRL_LOAD_USE;
                        next_state_s = ST_RUN;
                    end else begin
                        ctrl_s       = CTRL_RUN;
                        next_state_s = ST_RUN;
                    end
                end
                ST_HALT: begin
                    ctrl_s       = CTRL_HALT;
                    next_state_s = ST_HALT;
                end
                // Unreachable encoding: freeze the pipe this cycle and recover to RUN.
                default: begin
                    ctrl_s       = CTRL_STALL;
                    next_state_s = ST_RUN;
                end
            endcase
        end
    end

    // State register and saturating performance counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r     <= ST_RUN;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            // A halted core is not stalled, so HALT cycles are not counted.
            if (!ctrl_s.pc_we && (state_r != ST_HALT)) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (ctrl_s.if_id_flush) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign pc_write_en_o     = ctrl_s.pc_we;
    assign if_id_write_en_o  = ctrl_s.if_id_we;
    assign id_ex_write_en_o  = ctrl_s.id_ex_we;
    assign ex_mem_write_en_o = ctrl_s.ex_mem_we;
    assign mem_wb_write_en_o = ctrl_s.mem_wb_we;
    assign if_id_flush_o     = ctrl_s.if_id_flush;
    assign id_ex_flush_o     = ctrl_s.id_ex_flush;
    assign halted_o          = rst_ni && (state_r == ST_HALT);
    assign stall_count_o     = stall_cnt_r;
    assign flush_count_o     = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run against a behavioural model (halted flag + integer counters).
module tb_pipeline_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [4:0]  rs1_if_id_i, rs2_if_id_i, rd_id_ex_i;
    logic        rs1_used_if_id_en, rs2_used_if_id_en, mem_read_id_ex_en;
    logic        branch_taken_ex_i, dmem_busy_i, halt_ex_i;
    logic        pc_write_en_o, if_id_write_en_o, id_ex_write_en_o;
    logic        ex_mem_write_en_o, mem_wb_write_en_o;
    logic        if_id_flush_o, id_ex_flush_o, halted_o;
    logic [15:0] stall_count_o, flush_count_o;

    int n_vec = 0;
    int n_err = 0;
    bit m_halted = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    logic [6:0] out_vec;
    assign out_vec = {pc_write_en_o, if_id_write_en_o, id_ex_write_en_o,
                      ex_mem_write_en_o, mem_wb_write_en_o, if_id_flush_o, id_ex_flush_o};

    pipeline_hazard_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rs1_if_id_i(rs1_if_id_i), .rs2_if_id_i(rs2_if_id_i),
        .rs1_used_if_id_en(rs1_used_if_id_en), .rs2_used_if_id_en(rs2_used_if_id_en),
        .rd_id_ex_i(rd_id_ex_i), .mem_read_id_ex_en(mem_read_id_ex_en),
        .branch_taken_ex_i(branch_taken_ex_i), .dmem_busy_i(dmem_busy_i),
        .halt_ex_i(halt_ex_i),
        .pc_write_en_o(pc_write_en_o), .if_id_write_en_o(if_id_write_en_o),
        .id_ex_write_en_o(id_ex_write_en_o), .ex_mem_write_en_o(ex_mem_write_en_o),
        .mem_wb_write_en_o(mem_wb_write_en_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_flush_o(id_ex_flush_o), .halted_o(halted_o),
        .stall_count_o(stall_count_o), .flush_count_o(flush_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: expected control vector from the rules, given model state and inputs.
    function automatic logic [6:0] model_out();
        bit lu;
        lu = mem_read_id_ex_en && (rd_id_ex_i != 5'd0) &&
             ((rs1_used_if_id_en && rs1_if_id_i == rd_id_ex_i) ||
              (rs2_used_if_id_en && rs2_if_id_i == rd_id_ex_i));
        if (!rst_ni)           return 7'b0000011;
        if (m_halted)          return 7'b0001100;
        if (dmem_busy_i)       return 7'b0000000;
        if (halt_ex_i)         return 7'b0111111;
        if (branch_taken_ex_i) return 7'b1111111;
        if (lu)                return 7'b0011101;
        return 7'b1111100;
    endfunction

    // Advance one clock and update the model; no checking here.
    task automatic step();
        logic [6:0] e;
        e = model_out();
        @(posedge clk_i);
        if (!rst_ni) begin
            m_halted = 1'b0;
            m_stall  = 0;
            m_flush  = 0;
        end else begin
            if (!e[6] && !m_halted) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            if (e[1])               m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
            if (!m_halted && !dmem_busy_i && halt_ex_i) m_halted = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        rs1_if_id_i = 5'd0; rs2_if_id_i = 5'd0; rd_id_ex_i = 5'd0;
        rs1_used_if_id_en = 1'b0; rs2_used_if_id_en = 1'b0; mem_read_id_ex_en = 1'b0;
        branch_taken_ex_i = 1'b0; dmem_busy_i = 1'b0; halt_ex_i = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1);
        mem_read_id_ex_en = 1'b1; rd_id_ex_i = rd; rs1_if_id_i = rs1; rs1_used_if_id_en = u1;
    endtask

    task automatic test_reset();
        idle(); rst_ni = 1'b0; dmem_busy_i = 1'b1; halt_ex_i = 1'b1; #1;
        n_vec++;
        if (out_vec !== 7'b0000011 || halted_o !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs: got %b halted=%b, want 0000011 halted=0", out_vec, halted_o);
        end
        step();
        idle(); rst_ni = 1'b1; #1;
        n_vec++;
        if (stall_count_o !== 16'd0 || flush_count_o !== 16'd0 || out_vec !== 7'b1111100) begin
            n_err++; $display("FAIL reset_release: got ctl=%b stall=%0d flush=%0d, want 1111100 0 0",
                              out_vec, stall_count_o, flush_count_o);
        end
        step();
    endtask

    task automatic test_load_use();
        idle(); set_lu(5'd5, 5'd5, 1'b1); #1;
        n_vec++;
        if (out_vec !== 7'b0011101 || stall_count_o !== 16'd0) begin
            n_err++; $display("FAIL lu_rs1: got ctl=%b stall=%0d, want 0011101 0", out_vec, stall_count_o);
        end
        step();
        mem_read_id_ex_en = 1'b0; #1;
        n_vec++;
        if (stall_count_o !== 16'd1 || out_vec !== 7'b1111100) begin
            n_err++; $display("FAIL lu_one_bubble: got ctl=%b stall=%0d, want 1111100 1", out_vec, stall_count_o);
        end
        step();
        idle(); set_lu(5'd0, 5'd0, 1'b1); #1;
        n_vec++;
        if (out_vec !== 7'b1111100) begin
            n_err++; $display("FAIL lu_rd_zero: got %b, want 1111100", out_vec);
        end
        step();
        idle(); set_lu(5'd5, 5'd5, 1'b0); #1;
        n_vec++;
        if (out_vec !== 7'b1111100) begin
            n_err++; $display("FAIL lu_rs1_unused: got %b, want 1111100", out_vec);
        end
        step();
        rs2_if_id_i = 5'd5; rs2_used_if_id_en = 1'b1; #1;
        n_vec++;
        if (out_vec !== 7'b0011101) begin
            n_err++; $display("FAIL lu_rs2: got %b, want 0011101", out_vec);
        end
        step();
        n_vec++;
        if (stall_count_o !== 16'd2) begin
            n_err++; $display("FAIL lu_stall_count: got %0d, want 2", stall_count_o);
        end
        idle();
    endtask

    task automatic test_branch_lu();
        int s0, f0;
        s0 = m_stall; f0 = m_flush;
        idle(); set_lu(5'd7, 5'd7, 1'b1); branch_taken_ex_i = 1'b1; #1;
        n_vec++;
        if (out_vec !== 7'b1111111) begin
            n_err++; $display("FAIL branch_over_lu: got %b, want 1111111", out_vec);
        end
        step();
        n_vec++;
        if (stall_count_o !== 16'(s0) || flush_count_o !== 16'(f0 + 1)) begin
            n_err++; $display("FAIL branch_counters: got stall=%0d flush=%0d, want %0d %0d",
                              stall_count_o, flush_count_o, s0, f0 + 1);
        end
        idle();
    endtask

    task automatic test_mem_wait();
        int s0;
        s0 = m_stall;
        idle(); branch_taken_ex_i = 1'b1; dmem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (out_vec !== 7'b0000000) begin
                n_err++; $display("FAIL mem_busy_cycle%0d: got %b, want 0000000", i, out_vec);
            end
            step();
        end
        dmem_busy_i = 1'b0; #1;
        n_vec++;
        if (out_vec !== 7'b1111111) begin
            n_err++; $display("FAIL mem_release_branch: got %b, want 1111111", out_vec);
        end
        step();
        n_vec++;
        if (stall_count_o !== 16'(s0 + 3)) begin
            n_err++; $display("FAIL mem_stall_count: got %0d, want %0d", stall_count_o, s0 + 3);
        end
        // Reset while waiting on memory must leave no residual stall.
        idle(); dmem_busy_i = 1'b1; step();
        rst_ni = 1'b0; #1;
        n_vec++;
        if (out_vec !== 7'b0000011) begin
            n_err++; $display("FAIL mem_wait_reset: got %b, want 0000011", out_vec);
        end
        step();
        rst_ni = 1'b1; dmem_busy_i = 1'b0; #1;
        n_vec++;
        if (out_vec !== 7'b1111100 || stall_count_o !== 16'd0) begin
            n_err++; $display("FAIL mem_wait_after_reset: got ctl=%b stall=%0d, want 1111100 0",
                              out_vec, stall_count_o);
        end
        step();
    endtask

    task automatic test_halt();
        int s0;
        s0 = m_stall;
        idle(); halt_ex_i = 1'b1; set_lu(5'd3, 5'd3, 1'b1); #1;
        n_vec++;
        if (out_vec !== 7'b0111111 || halted_o !== 1'b0) begin
            n_err++; $display("FAIL halt_drain: got %b halted=%b, want 0111111 halted=0", out_vec, halted_o);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            halt_ex_i = 1'($urandom_range(0, 1)); branch_taken_ex_i = 1'($urandom_range(0, 1));
            dmem_busy_i = 1'($urandom_range(0, 1)); #1;
            n_vec++;
            if (out_vec !== 7'b0001100 || halted_o !== 1'b1) begin
                n_err++; $display("FAIL halt_sticky%0d: got %b halted=%b, want 0001100 halted=1", i, out_vec, halted_o);
            end
            step();
        end
        n_vec++;
        if (stall_count_o !== 16'(s0 + 1)) begin
            n_err++; $display("FAIL halt_stall_count: got %0d, want %0d", stall_count_o, s0 + 1);
        end
        idle(); rst_ni = 1'b0; step();
        rst_ni = 1'b1; #1;
        n_vec++;
        if (halted_o !== 1'b0 || out_vec !== 7'b1111100 || stall_count_o !== 16'd0 || flush_count_o !== 16'd0) begin
            n_err++; $display("FAIL halt_reset_exit: got halted=%b ctl=%b stall=%0d flush=%0d, want 0 1111100 0 0",
                              halted_o, out_vec, stall_count_o, flush_count_o);
        end
        step();
    endtask

    task automatic test_random();
        logic [6:0] e;
        for (int i = 0; i < 600; i++) begin
            rst_ni            = ($urandom_range(0, 63) != 0);
            rs1_if_id_i       = 5'($urandom_range(0, 3));
            rs2_if_id_i       = 5'($urandom_range(0, 3));
            rd_id_ex_i        = 5'($urandom_range(0, 3));
            rs1_used_if_id_en = 1'($urandom_range(0, 1));
            rs2_used_if_id_en = 1'($urandom_range(0, 1));
            mem_read_id_ex_en = 1'($urandom_range(0, 1));
            branch_taken_ex_i = ($urandom_range(0, 4) == 0);
            dmem_busy_i       = ($urandom_range(0, 3) == 0);
            halt_ex_i         = ($urandom_range(0, 39) == 0);
            #1;
            e = model_out();
            n_vec++;
            if (out_vec !== e || halted_o !== (m_halted && rst_ni)) begin
                n_err++; $display("FAIL rand_ctl%0d: got %b halted=%b, want %b halted=%b",
                                  i, out_vec, halted_o, e, m_halted && rst_ni);
            end
            step();
            n_vec++;
            if (stall_count_o !== m_stall[15:0] || flush_count_o !== m_flush[15:0]) begin
                n_err++; $display("FAIL rand_cnt%0d: got stall=%0d flush=%0d, want %0d %0d",
                                  i, stall_count_o, flush_count_o, m_stall, m_flush);
            end
        end
        idle(); rst_ni = 1'b1;
    endtask

    task automatic test_saturation();
        idle(); rst_ni = 1'b0; step();
        rst_ni = 1'b1; set_lu(5'd9, 5'd9, 1'b1);
        for (int i = 0; i < 65534; i++) step();
        n_vec++;
        if (stall_count_o !== 16'hFFFE) begin
            n_err++; $display("FAIL sat_before: got %h, want fffe", stall_count_o);
        end
        for (int i = 0; i < 4466; i++) step();
        n_vec++;
        if (stall_count_o !== 16'hFFFF || flush_count_o !== 16'd0) begin
            n_err++; $display("FAIL sat_hold: got stall=%h flush=%0d, want ffff 0", stall_count_o, flush_count_o);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_lu();
        test_mem_wait();
        test_halt();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
